commit_trace_serializer: RTL and testbench
==========================================

// Module: commit_trace_serializer
// PURPOSE
// - Source side of the 2-lane commit stream that the commit log monitor consumes from writeback.
// - Captures up to two retiring records per cycle (commit_valid_i/commit_data_i, drac_pkg::commit_data_t) into a FIFO.
// - Re-emits them in program order, one per cycle, on a valid/ready trace port for an off-core trace sink or checker.
// - Accounts for records lost on overflow; never stalls the core.
// PARAMETERS
// - DEPTH  16  FIFO entries; power of 2, >= 4
// - TS_W   32  timestamp width; used only with COMMIT_TRACE_TIMESTAMP_EN
// PORTS
// - clk             in   1              core clock; single clock domain
// - rst             in   1              reset; synchronous, active-high
// - commit_valid_i  in   1 x [1:0]      per-lane commit valid; lane 0 is older
// - commit_data_i   in   commit_data_t x [1:0]  per-lane commit record
// - trace_valid_o   out  1              head record valid
// - trace_ready_i   in   1              sink accepts head this cycle
// - trace_data_o    out  commit_data_t  head record
// - trace_lane_o    out  1              lane the head record came from
// - trace_ts_o      out  TS_W           head timestamp (macro only)
// - occupancy_o     out  $clog2(DEPTH)+1  entries held
// - drop_cnt_o      out  32             records dropped, saturating
// - overflow_o      out  1              sticky: any drop since reset
// BEHAVIOUR
// - Reset: rd/wr ptr=0, count=0; trace_valid_o=0, trace_lane_o=0, occupancy_o=0, drop_cnt_o=0, overflow_o=0, trace_ts_o=0.
// - Storage array is not reset. trace_data_o/lane/ts are driven '0 whenever trace_valid_o=0.
// - pop = trace_valid_o & trace_ready_i; trace_valid_o = (count != 0).
// - Head is registered storage (FWFT): a record written in cycle N is visible at the output in cycle N+1 at the earliest; never combinational in->out.
// - Head data/lane/ts hold stable while trace_valid_o & !trace_ready_i.
// - space = DEPTH - count + pop. Same-cycle pop frees a slot, so push at full with pop succeeds.
// - Enqueue order: lane 0 then lane 1 when both are valid. A lone lane-1 commit is legal and tagged lane=1.
// - n_req = number of valid lanes (0..2).
// - If space >= n_req: all requested records are written.
// - If space == 1 and n_req == 2: lane 0 written, lane 1 dropped.
// - If space == 0: all requested records dropped.
// - drop_cnt_o += dropped (0..2), saturating at 32'hFFFF_FFFF.
// - overflow_o set on any drop; cleared only by rst.
// - count_next = count + written - pop. Ptrs are $clog2(DEPTH) bits and wrap naturally; count never exceeds DEPTH.
// - Reset mid-stream: all held records discarded next cycle. Commits presented in the rst cycle are ignored, with no drop counted.
// - No FSM beyond the FIFO control. Asserts (sim only): trace_ready_i never X after reset; count <= DEPTH.
// CONFIGURATION
// - COMMIT_TRACE_TIMESTAMP_EN defined:
//   - Free-running TS_W cycle counter; 0 in the rst cycle, +1 every cycle rst=0, wraps.
//   - Each record stores the counter value of its enqueue cycle; both lanes of one cycle share a timestamp.
//   - Timestamp is presented on trace_ts_o.
// - COMMIT_TRACE_TIMESTAMP_EN undefined: trace_ts_o port, counter and per-entry ts storage are absent. All else identical.
// TESTING
// - T1: lane0 only, ready=1 -> next cycle valid=1, lane=0, data matches; valid=0 the cycle after.
// - T2: both lanes, data A/B, ready=1 -> A (lane 0) then B (lane 1) on consecutive cycles; occupancy 2,1,0.
// - T3: ready=0, 8 cycles of dual commits (DEPTH=16) -> occupancy=16.
//   Next dual commit -> drop_cnt=2, overflow=1, occupancy=16.
// - T4: occupancy=16, ready=1, one lane-0 commit -> no drop; occupancy stays 16; popped head is the oldest.
//   Then occupancy=15, ready=0, dual commit -> lane 0 stored, drop_cnt +1.
// - T5: occupancy=5, drop_cnt=3, assert rst one cycle with commits valid -> next cycle valid=0, occupancy=0, drop_cnt=0, overflow=0.
// - T6 (macro on): rst release at cycle 0; commits in cycles 3 and 7; ready=0 until cycle 10 -> trace_ts_o=3 then 7.

Source files
------------

// File: rtl/drac_pkg.sv
// Shared commit-record payload carried from writeback to the trace logic.
package drac_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] rd_data;
  } commit_data_t;

endpackage

// File: rtl/commit_trace_serializer_if.sv
// Commit-in / trace-out bundle for commit_trace_serializer.
// trace_ts_o exists only when COMMIT_TRACE_TIMESTAMP_EN is defined.
interface commit_trace_serializer_if #(
  parameter int unsigned TS_W = 32
);
  import drac_pkg::*;

  logic [1:0]         commit_valid_i;
  commit_data_t [1:0] commit_data_i;
  logic               trace_valid_o;
  logic               trace_ready_i;
  commit_data_t       trace_data_o;
  logic               trace_lane_o;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]    trace_ts_o;
`endif

  // Producer of commits and consumer of the trace stream
  modport master (
    output commit_valid_i, commit_data_i, trace_ready_i,
    input  trace_valid_o, trace_data_o, trace_lane_o
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    , input trace_ts_o
`endif
  );

  // The serializer itself
  modport slave (
    input  commit_valid_i, commit_data_i, trace_ready_i,
    output trace_valid_o, trace_data_o, trace_lane_o
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    , output trace_ts_o
`endif
  );

endinterface

// File: rtl/commit_trace_serializer.sv
// commit_trace_serializer: captures up to two retiring records per cycle into a
// FIFO and re-emits them in program order, one per cycle, on a valid/ready port.
// Records that do not fit are dropped and counted; the core is never stalled.
// Optional feature macro: COMMIT_TRACE_TIMESTAMP_EN (per-record cycle timestamp).
module commit_trace_serializer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  commit_trace_serializer_if.slave  bus,
  output logic [$clog2(DEPTH):0]    occupancy_o,
  output logic [31:0]               drop_cnt_o,
  output logic                      overflow_o
);
  import drac_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic [31:0]   r_drop;
  logic          r_ovf;

  commit_data_t  r_mem_data [DEPTH];
  logic          r_mem_lane [DEPTH];

  logic          w_pop;
  logic [1:0]    w_n_req;
  logic [1:0]    w_n_wr;
  logic [1:0]    w_n_drop;
  logic [CW-1:0] w_space;
  logic [CW-1:0] w_count_next;
  logic [32:0]   w_drop_sum;
  commit_data_t  w_first_data;
  logic          w_first_lane;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_mem_ts [DEPTH];
`endif

  // Admission control: how many requested records fit this cycle
  always_comb begin
    w_pop        = r_valid & bus.trace_ready_i;
    w_n_req      = 2'({1'b0, bus.commit_valid_i[0]}) + 2'({1'b0, bus.commit_valid_i[1]});
    w_space      = CW'(DEPTH) - r_count + CW'(w_pop);
    w_n_wr       = w_n_req;
    if (w_space < CW'(w_n_req)) begin
      w_n_wr = w_space[1:0];
    end
    w_n_drop     = w_n_req - w_n_wr;
    w_count_next = r_count + CW'(w_n_wr) - CW'(w_pop);
    w_drop_sum   = {1'b0, r_drop} + 33'(w_n_drop);
    // A lone lane-1 commit takes the first write slot
    w_first_data = bus.commit_valid_i[0] ? bus.commit_data_i[0] : bus.commit_data_i[1];
    w_first_lane = ~bus.commit_valid_i[0];
  end

  // FIFO control, drop accounting and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_drop   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_wr_ptr <= r_wr_ptr + PW'(w_n_wr);
      r_count  <= w_count_next;
      r_valid  <= (w_count_next != '0);
      r_drop   <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
      r_ovf    <= r_ovf | (w_n_drop != 2'd0);
    end
  end

  // Record storage; not reset, and commits in the reset cycle are ignored
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_n_wr != 2'd0) begin
        r_mem_data[r_wr_ptr] <= w_first_data;
        r_mem_lane[r_wr_ptr] <= w_first_lane;
      end
      if (w_n_wr == 2'd2) begin
        r_mem_data[r_wr_ptr + PW'(1)] <= bus.commit_data_i[1];
        r_mem_lane[r_wr_ptr + PW'(1)] <= 1'b1;
      end
    end
  end

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  // Free-running cycle counter, zero in the first cycle after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  // Both lanes of one cycle share the enqueue timestamp
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_n_wr != 2'd0) begin
        r_mem_ts[r_wr_ptr] <= r_ts;
      end
      if (w_n_wr == 2'd2) begin
        r_mem_ts[r_wr_ptr + PW'(1)] <= r_ts;
      end
    end
  end

  assign bus.trace_ts_o = r_valid ? r_mem_ts[r_rd_ptr] : '0;
`endif

  // Head is read straight from registered storage; zeroed when empty
  assign bus.trace_valid_o = r_valid;
  assign bus.trace_data_o  = r_valid ? r_mem_data[r_rd_ptr] : '0;
  assign bus.trace_lane_o  = r_valid ? r_mem_lane[r_rd_ptr] : 1'b0;
  assign occupancy_o       = r_count;
  assign drop_cnt_o        = r_drop;
  assign overflow_o        = r_ovf;

`ifndef SYNTHESIS
  // Simulation-only sanity checks
  a_ready_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(bus.trace_ready_i));
  a_count_max:   assert property (@(posedge clk) disable iff (rst) r_count <= CW'(DEPTH));
`endif

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Bench for commit_trace_serializer: vector table plus directed overflow,
// reset and timestamp sequences, with a scoreboard for the output stream.
module tb_commit_trace_serializer;
  import drac_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [4:0]  occupancy_o;
  logic [31:0] drop_cnt_o;
  logic        overflow_o;

  commit_trace_serializer_if #(.TS_W(32)) bus ();

  commit_trace_serializer #(.DEPTH(DEPTH), .TS_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .occupancy_o (occupancy_o),
    .drop_cnt_o  (drop_cnt_o),
    .overflow_o  (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    commit_data_t data;
    logic         lane;
    logic [31:0]  ts;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [1:0] v;
    logic       rdy;
    int         keep;
    int         occ;
    logic       valid;
    int         drop;
    logic       ovf;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[14];
  int   n_chk;
  int   n_pass;
  logic [31:0] tb_ts;

  // Bench copy of the enqueue-cycle timestamp
  always @(posedge clk) begin
    if (rst) tb_ts <= 32'd0;
    else     tb_ts <= tb_ts + 32'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_rec(input string name, input commit_data_t act, input commit_data_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic commit_data_t rand_rec();
    commit_data_t r;
    r.pc      = $urandom;
    r.inst    = $urandom;
    r.rd      = 5'($urandom);
    r.rd_we   = 1'($urandom);
    r.rd_data = $urandom;
    return r;
  endfunction

  // One clock cycle: drive, push expected records, check head, advance
  task automatic cycle(input logic rst_v, input logic [1:0] v, input logic rdy, input int keep);
    commit_data_t d0;
    commit_data_t d1;
    exp_t e;
    d0 = rand_rec();
    d1 = rand_rec();
    rst = rst_v;
    bus.commit_valid_i   = v;
    bus.commit_data_i[0] = d0;
    bus.commit_data_i[1] = d1;
    bus.trace_ready_i    = rdy;
    if (!rst_v) begin
      if (keep >= 1) begin
        e.data = v[0] ? d0 : d1;
        e.lane = ~v[0];
        e.ts   = tb_ts;
        sb.push_back(e);
      end
      if (keep == 2) begin
        e.data = d1;
        e.lane = 1'b1;
        e.ts   = tb_ts;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    if (!rst_v && bus.trace_valid_o === 1'b1 && rdy) begin
      if (sb.size() == 0) begin
        chk("head_unexpected", 64'd1, 64'd0);
      end else begin
        chk_rec("head_data", bus.trace_data_o, sb[0].data);
        chk("head_lane", 64'(bus.trace_lane_o), 64'(sb[0].lane));
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        chk("head_ts", 64'(bus.trace_ts_o), 64'(sb[0].ts));
`endif
        void'(sb.pop_front());
      end
    end
    if (bus.trace_valid_o === 1'b0) begin
      chk("idle_data_zero", 64'(bus.trace_data_o == '0), 64'd1);
      chk("idle_lane_zero", 64'(bus.trace_lane_o), 64'd0);
    end
    @(posedge clk);
    #1;
    if (rst_v) sb.delete();
  endtask

  task automatic status(input string name, input int occ, input logic valid, input int drop, input logic ovf);
    chk({name, "_occ"},   64'(occupancy_o),       64'(occ));
    chk({name, "_valid"}, 64'(bus.trace_valid_o), 64'(valid));
    chk({name, "_drop"},  64'(drop_cnt_o),        64'(drop));
    chk({name, "_ovf"},   64'(overflow_o),        64'(ovf));
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (bus.trace_valid_o === 1'b1 && guard < 40) begin
      cycle(1'b0, 2'b00, 1'b1, 0);
      guard++;
    end
    chk({name, "_drained_occ"}, 64'(occupancy_o), 64'd0);
    chk({name, "_sb_empty"},    64'(sb.size()),   64'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    bus.commit_valid_i = 2'b00;
    bus.commit_data_i  = '0;
    bus.trace_ready_i  = 1'b0;

    //        rst   v      rdy  keep occ val drop ovf
    tbl[0]  = '{1'b1, 2'b00, 1'b0, 0, 0, 1'b0, 0, 1'b0};
    tbl[1]  = '{1'b0, 2'b01, 1'b1, 1, 1, 1'b1, 0, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 0, 0, 1'b0, 0, 1'b0};
    tbl[3]  = '{1'b0, 2'b11, 1'b1, 2, 2, 1'b1, 0, 1'b0};
    tbl[4]  = '{1'b0, 2'b00, 1'b1, 0, 1, 1'b1, 0, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 1'b1, 0, 0, 1'b0, 0, 1'b0};
    tbl[6]  = '{1'b0, 2'b10, 1'b0, 1, 1, 1'b1, 0, 1'b0};
    tbl[7]  = '{1'b0, 2'b11, 1'b0, 2, 3, 1'b1, 0, 1'b0};
    tbl[8]  = '{1'b0, 2'b01, 1'b1, 1, 3, 1'b1, 0, 1'b0};
    tbl[9]  = '{1'b0, 2'b11, 1'b1, 2, 4, 1'b1, 0, 1'b0};
    tbl[10] = '{1'b0, 2'b00, 1'b1, 0, 3, 1'b1, 0, 1'b0};
    tbl[11] = '{1'b0, 2'b00, 1'b1, 0, 2, 1'b1, 0, 1'b0};
    tbl[12] = '{1'b0, 2'b00, 1'b1, 0, 1, 1'b1, 0, 1'b0};
    tbl[13] = '{1'b0, 2'b00, 1'b1, 0, 0, 1'b0, 0, 1'b0};

    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].rst, tbl[i].v, tbl[i].rdy, tbl[i].keep);
      status($sformatf("vec%0d", i), tbl[i].occ, tbl[i].valid, tbl[i].drop, tbl[i].ovf);
    end

    // Fill to full with dual commits, then overflow by two
    for (int i = 0; i < 8; i++) cycle(1'b0, 2'b11, 1'b0, 2);
    status("full", 16, 1'b1, 0, 1'b0);
    cycle(1'b0, 2'b11, 1'b0, 0);
    status("overflow2", 16, 1'b1, 2, 1'b1);

    // Push at full with a same-cycle pop is accepted
    cycle(1'b0, 2'b01, 1'b1, 1);
    status("full_pop_push", 16, 1'b1, 2, 1'b1);
    cycle(1'b0, 2'b00, 1'b1, 0);
    status("one_free", 15, 1'b1, 2, 1'b1);
    cycle(1'b0, 2'b11, 1'b0, 1);
    status("partial_drop", 16, 1'b1, 3, 1'b1);

    // Drain to five entries, then reset with commits presented
    for (int i = 0; i < 11; i++) cycle(1'b0, 2'b00, 1'b1, 0);
    status("pre_rst", 5, 1'b1, 3, 1'b1);
    cycle(1'b1, 2'b11, 1'b1, 0);
    status("mid_rst", 0, 1'b0, 0, 1'b0);
    cycle(1'b0, 2'b00, 1'b1, 0);
    status("post_rst", 0, 1'b0, 0, 1'b0);

    // Single-lane commits at full are dropped one at a time
    for (int i = 0; i < 8; i++) cycle(1'b0, 2'b11, 1'b0, 2);
    cycle(1'b0, 2'b01, 1'b0, 0);
    status("full_lane0_drop", 16, 1'b1, 1, 1'b1);
    cycle(1'b0, 2'b10, 1'b0, 0);
    status("full_lane1_drop", 16, 1'b1, 2, 1'b1);
    drain("refill");

`ifdef COMMIT_TRACE_TIMESTAMP_EN
    // Timestamps: release at cycle 0, commits at cycles 3 and 7, sink ready from cycle 10
    cycle(1'b1, 2'b00, 1'b0, 0);
    for (int c = 0; c < 13; c++) begin
      cycle(1'b0, (c == 3 || c == 7) ? 2'b01 : 2'b00, (c >= 10) ? 1'b1 : 1'b0,
            (c == 3 || c == 7) ? 1 : 0);
      if (c == 9) begin
        chk("ts_first_valid", 64'(bus.trace_valid_o), 64'd1);
        chk("ts_first", 64'(bus.trace_ts_o), 64'd3);
      end
      if (c == 10) chk("ts_second", 64'(bus.trace_ts_o), 64'd7);
    end
    chk("ts_done_occ", 64'(occupancy_o), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
